input_fetch_scheduler: RTL and testbench

//  Sequences input_data_rom across one conv layer: walks input channels and output row-bands, drives one tile at a time.
//  Per tile: issues initial_address/offset/write_enable pattern, holds enable until completed, waits for array to drain.

---
 rtl/cnn_pkg.sv | 32 +++
 rtl/fetch_addr_gen.sv | 94 +++++++++
 rtl/input_fetch_scheduler.sv | 143 ++++++++++++++
 tb/tb_input_fetch_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and constants for the conv-layer input fetch path.
// Holds the scheduler FSM encoding and a shift-add product helper.
package cnn_pkg;

    localparam int ADDR_WIDTH = 20;
    localparam int DIM_WIDTH  = 8;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SETUP,
        LAUNCH,
        WAIT_FILL,
        WAIT_DRAIN,
        NEXT,
        DONE
    } state_t;

    // Product built from conditional shifted adds only; evaluated once per layer.
    function automatic logic [31:0] shift_add_mul(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) acc = acc + ({16'b0, a} << i);
        end
        return acc;
    endfunction

endpackage

// File: rtl/fetch_addr_gen.sv
// Channel/tile counters and accumulating address generator.
// Produces the tile address, first output row, FIFO mask and carry flag.
module fetch_addr_gen
    import cnn_pkg::*;
#(
    parameter int array_size    = 9,
    parameter int dim_data_size = DIM_WIDTH,
    parameter int addr_width    = ADDR_WIDTH,
    parameter int ch_width      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic                     advance_tile,
    input  logic                     advance_ch,
    input  logic [addr_width-1:0]    base_address,
    input  logic [dim_data_size-1:0] image_height,
    input  logic [dim_data_size-1:0] image_width,
    input  logic [dim_data_size-1:0] weight_size,
    input  logic [ch_width-1:0]      num_channels,
    output logic [addr_width-1:0]    tile_address,
    output logic [dim_data_size-1:0] tile_offset,
    output logic [array_size-1:0]    tile_mask,
    output logic                     last_tile,
    output logic                     last_ch,
    output logic                     carry
);

    localparam logic [dim_data_size:0]   rows_step = (dim_data_size+1)'(array_size);
    localparam logic [dim_data_size-1:0] off_step  = dim_data_size'(array_size);
    localparam logic [array_size-1:0]    full_mask = '1;

    logic [addr_width-1:0]    ch_base;
    logic [addr_width-1:0]    row_addr;
    logic [addr_width-1:0]    plane;
    logic [addr_width-1:0]    row_step;
    logic [dim_data_size-1:0] offset_q;
    logic [dim_data_size:0]   rows_total;
    logic [dim_data_size:0]   rows_left;
    logic [dim_data_size:0]   rows_init;
    logic [ch_width-1:0]      ch_cnt;
    logic [addr_width:0]      tile_sum;
    logic [addr_width:0]      ch_sum;

    assign rows_init = {1'b0, image_height} - {1'b0, weight_size} + 1'b1;
    assign tile_sum  = {1'b0, row_addr} + {1'b0, row_step};
    assign ch_sum    = {1'b0, ch_base} + {1'b0, plane};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch_base    <= '0;
            row_addr   <= '0;
            plane      <= '0;
            row_step   <= '0;
            offset_q   <= '0;
            rows_total <= '0;
            rows_left  <= '0;
            ch_cnt     <= '0;
        end else if (load) begin
            ch_base    <= base_address;
            row_addr   <= base_address;
            plane      <= addr_width'(shift_add_mul(16'(image_height), 16'(image_width)));
            row_step   <= addr_width'(shift_add_mul(16'(array_size), 16'(image_width)));
            offset_q   <= '0;
            rows_total <= rows_init;
            rows_left  <= rows_init;
            ch_cnt     <= '0;
        end else if (advance_ch) begin
            ch_base   <= ch_sum[addr_width-1:0];
            row_addr  <= ch_sum[addr_width-1:0];
            offset_q  <= '0;
            rows_left <= rows_total;
            ch_cnt    <= ch_cnt + 1'b1;
        end else if (advance_tile) begin
            row_addr  <= tile_sum[addr_width-1:0];
            offset_q  <= offset_q + off_step;
            rows_left <= rows_left - rows_step;
        end
    end

    // Only the last tile of a channel can be partial.
    always_comb begin
        tile_mask = full_mask;
        if (rows_left < rows_step) tile_mask = ~(full_mask << rows_left);
    end

    assign tile_address = row_addr;
    assign tile_offset  = offset_q;
    assign last_tile    = (rows_left <= rows_step);
    assign last_ch      = (ch_cnt == num_channels - 1'b1);
    assign carry        = (advance_tile & tile_sum[addr_width])
                        | (advance_ch & ch_sum[addr_width]);

endmodule

// File: rtl/input_fetch_scheduler.sv
// Walks channels and row-bands of one conv layer, issuing one ROM fill
// per tile and waiting for the array to drain before the next.
module input_fetch_scheduler
    import cnn_pkg::*;
#(
    parameter int array_size    = 9,
    parameter int dim_data_size = DIM_WIDTH,
    parameter int addr_width    = ADDR_WIDTH,
    parameter int ch_width      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [addr_width-1:0]    base_address,
    input  logic [dim_data_size-1:0] image_height,
    input  logic [dim_data_size-1:0] image_width,
    input  logic [dim_data_size-1:0] weight_size,
    input  logic [ch_width-1:0]      num_channels,
    input  logic                     array_ready,
    input  logic                     fill_completed,
    output logic                     fill_clear,
    output logic                     fill_enable,
    output logic [addr_width-1:0]    initial_address,
    output logic [dim_data_size-1:0] offset,
    output logic [array_size-1:0]    write_enable,
    output logic                     tile_valid,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    state_t state, state_nx;

    logic [addr_width-1:0]    base_q;
    logic [dim_data_size-1:0] h_q, w_q, k_q;
    logic [ch_width-1:0]      c_q;
    logic                     err_q;
    logic                     load, adv_tile, adv_ch;
    logic                     last_tile, last_ch, carry;
    logic                     cfg_bad, accept, active;
    logic [addr_width-1:0]    tile_address;
    logic [dim_data_size-1:0] tile_offset;
    logic [array_size-1:0]    tile_mask;

    assign accept  = (state == IDLE) && start;
    assign cfg_bad = (k_q == '0) || (k_q > h_q) || (k_q > w_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q <= '0;
            h_q    <= '0;
            w_q    <= '0;
            k_q    <= '0;
            c_q    <= '0;
        end else if (accept) begin
            base_q <= base_address;
            h_q    <= image_height;
            w_q    <= image_width;
            k_q    <= weight_size;
            c_q    <= num_channels;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                   err_q <= 1'b0;
        else if (accept)                              err_q <= 1'b0;
        else if ((state == CHECK && cfg_bad) || carry) err_q <= 1'b1;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        adv_tile = 1'b0;
        adv_ch   = 1'b0;
        unique case (state)
            IDLE:       if (start) state_nx = CHECK;
            CHECK: begin
                load = 1'b1;
                if (cfg_bad || c_q == '0) state_nx = DONE;
                else                      state_nx = SETUP;
            end
            SETUP:      state_nx = LAUNCH;
            LAUNCH:     state_nx = WAIT_FILL;
            WAIT_FILL:  if (fill_completed) state_nx = WAIT_DRAIN;
            WAIT_DRAIN: if (array_ready) state_nx = NEXT;
            NEXT: begin
                if (last_tile && last_ch) begin
                    state_nx = DONE;
                end else begin
                    state_nx = SETUP;
                    adv_ch   = last_tile;
                    adv_tile = !last_tile;
                end
            end
            DONE:       state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    fetch_addr_gen #(
        .array_size    (array_size),
        .dim_data_size (dim_data_size),
        .addr_width    (addr_width),
        .ch_width      (ch_width)
    ) u_gen (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .advance_tile (adv_tile),
        .advance_ch   (adv_ch),
        .base_address (base_q),
        .image_height (h_q),
        .image_width  (w_q),
        .weight_size  (k_q),
        .num_channels (c_q),
        .tile_address (tile_address),
        .tile_offset  (tile_offset),
        .tile_mask    (tile_mask),
        .last_tile    (last_tile),
        .last_ch      (last_ch),
        .carry        (carry)
    );

    // Tile fields are only presented while a tile is in flight.
    assign active = (state == SETUP) || (state == LAUNCH)
                 || (state == WAIT_FILL) || (state == WAIT_DRAIN);

    assign initial_address = active ? tile_address : '0;
    assign offset          = active ? tile_offset : '0;
    assign write_enable    = active ? tile_mask : '0;
    assign fill_clear      = (state == SETUP);
    assign fill_enable     = (state == LAUNCH) || (state == WAIT_FILL);
    assign tile_valid      = (state == WAIT_DRAIN);
    assign busy            = (state != IDLE) && (state != DONE);
    assign done            = (state == DONE);
    assign err             = err_q;

endmodule

// File: tb/tb_input_fetch_scheduler.sv
// Table-driven and randomized bench for input_fetch_scheduler with a
// tile-list reference model computed directly from layer geometry.
module tb_input_fetch_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [19:0] base_address = '0;
    logic [7:0]  image_height = '0;
    logic [7:0]  image_width = '0;
    logic [7:0]  weight_size = '0;
    logic [7:0]  num_channels = '0;
    logic        array_ready = 1'b0;
    logic        fill_completed = 1'b0;
    logic        fill_clear, fill_enable, tile_valid, busy, done, err;
    logic [19:0] initial_address;
    logic [7:0]  offset;
    logic [8:0]  write_enable;

    input_fetch_scheduler dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .base_address    (base_address),
        .image_height    (image_height),
        .image_width     (image_width),
        .weight_size     (weight_size),
        .num_channels    (num_channels),
        .array_ready     (array_ready),
        .fill_completed  (fill_completed),
        .fill_clear      (fill_clear),
        .fill_enable     (fill_enable),
        .initial_address (initial_address),
        .offset          (offset),
        .write_enable    (write_enable),
        .tile_valid      (tile_valid),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] base;
        int h, w, k, c, fd, rd;
        int n_tiles;
        bit e_err;
        int a0, alast, mlast;
        int fe_at, done_at, fe_cyc, tv_cyc;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [19:0] q_addr[$];
    logic [7:0]  q_off[$];
    logic [8:0]  q_mask[$];
    int          q_fe[$];
    int          q_tv[$];
    int          stab_bad, dones, r_first_fe, r_done_at;
    bit          r_err;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_layer(input logic [19:0] b, input int h, input int w,
                             input int k, input int c, input int fd,
                             input int rd, input int abort_tile);
        bit finished;
        int fcnt, rcnt;
        q_addr.delete(); q_off.delete(); q_mask.delete();
        q_fe.delete(); q_tv.delete();
        stab_bad = 0; dones = 0; r_first_fe = -1; r_done_at = -1; r_err = 0;
        finished = 0; fcnt = 0; rcnt = 0;
        @(negedge clk);
        base_address = b;
        image_height = 8'(h);
        image_width  = 8'(w);
        weight_size  = 8'(k);
        num_channels = 8'(c);
        start = 1'b1;
        fill_completed = 1'b0;
        array_ready = (rd == 0);
        for (int n = 1; n <= 20000; n++) begin
            @(negedge clk);
            // Config inputs are garbage after start; a second start arrives mid-layer.
            start = (n == 4) && busy;
            base_address = 20'($urandom);
            image_height = 8'($urandom);
            image_width  = 8'($urandom);
            weight_size  = 8'($urandom);
            num_channels = 8'($urandom);
            if (fill_clear) begin
                q_addr.push_back(initial_address);
                q_off.push_back(offset);
                q_mask.push_back(write_enable);
                q_fe.push_back(0);
                q_tv.push_back(0);
                fcnt = 0;
                rcnt = 0;
            end
            if (q_addr.size() > 0 && (fill_enable || tile_valid)) begin
                if (initial_address != q_addr[$] || offset != q_off[$]
                    || write_enable != q_mask[$]) stab_bad++;
            end
            if (fill_enable && tile_valid) stab_bad++;
            if (fill_enable) begin
                if (r_first_fe < 0) r_first_fe = n;
                if (q_fe.size() > 0) q_fe[q_fe.size()-1]++;
                fcnt++;
            end
            if (tile_valid) begin
                if (q_tv.size() > 0) q_tv[q_tv.size()-1]++;
                rcnt++;
            end
            fill_completed = fill_enable && (fcnt >= fd);
            array_ready = (rd == 0) || (tile_valid && rcnt >= rd);
            if (done) begin
                dones++;
                r_done_at = n;
                r_err = err;
                if (busy) stab_bad++;
                finished = 1;
                break;
            end
            if (abort_tile > 0 && q_fe.size() == abort_tile && fill_enable
                && q_fe[q_fe.size()-1] >= 2) begin
                #2 reset = 1'b0;
                #1 check("reset outputs",
                         {fill_clear, fill_enable, initial_address, offset,
                          write_enable, tile_valid, busy, done, err}, 0);
                repeat (2) begin
                    @(posedge clk);
                    #1 check("reset no done", done, 0);
                end
                @(negedge clk);
                reset = 1'b1;
                fill_completed = 1'b0;
                array_ready = 1'b0;
                finished = 1;
                break;
            end
        end
        start = 1'b0;
        fill_completed = 1'b0;
        if (!finished) check("timeout", 1, 0);
    endtask

    // Expected tiles from geometry: address = base + ch*H*W + t*rows*W (mod 2^20).
    task automatic model_check(input string tag, input logic [19:0] b,
                               input int h, input int w, input int k, input int c);
        longint e_addr[$];
        int     e_off[$];
        int     e_mask[$];
        bit     bad, eerr;
        int     r, rows;
        longint tru;
        int     m;
        r = h - k + 1;
        bad = (k == 0) || (k > h) || (k > w);
        eerr = bad;
        if (!bad) begin
            for (int ch = 0; ch < c; ch++) begin
                for (int t = 0; t * 9 < r; t++) begin
                    tru = longint'(b) + longint'(ch) * h * w + longint'(t) * 9 * w;
                    if (tru >= 64'h100000) eerr = 1;
                    e_addr.push_back(tru % 64'h100000);
                    e_off.push_back(t * 9);
                    rows = (r - t * 9 > 9) ? 9 : r - t * 9;
                    e_mask.push_back((1 << rows) - 1);
                end
            end
        end
        check({tag, " tiles"}, q_addr.size(), e_addr.size());
        m = (q_addr.size() < e_addr.size()) ? q_addr.size() : e_addr.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s addr[%0d]", tag, i), q_addr[i], e_addr[i]);
            check($sformatf("%s off[%0d]", tag, i), q_off[i], e_off[i]);
            check($sformatf("%s mask[%0d]", tag, i), q_mask[i], e_mask[i]);
        end
        check({tag, " err"}, r_err, eerr);
        check({tag, " dones"}, dones, 1);
        check({tag, " stable"}, stab_bad, 0);
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{20'h00100, 28, 28, 3, 1, 3, 0, 3, 0, 'h100, 'h2F8, 'hFF, 3, -1, 0, 1};
        tbl[1]  = '{20'h00100, 28, 28, 3, 2, 4, 2, 6, 0, 'h100, 'h608, 'hFF, 3, -1, 0, 0};
        tbl[2]  = '{20'h00000, 4, 28, 5, 1, 2, 0, 0, 1, 0, 0, 0, -1, 2, 0, 0};
        tbl[3]  = '{20'h00100, 28, 28, 3, 0, 2, 0, 0, 0, 0, 0, 0, -1, 2, 0, 0};
        tbl[4]  = '{20'hFFF00, 28, 28, 3, 2, 1, 1, 6, 1, 'hFFF00, 'h408, 'hFF, 3, -1, 0, 0};
        tbl[5]  = '{20'h00100, 28, 28, 3, 1, 50, 20, 3, 0, 'h100, 'h2F8, 'hFF, 3, -1, 50, 20};
        tbl[6]  = '{20'h00040, 11, 5, 3, 1, 2, 1, 1, 0, 'h40, 'h40, 'h1FF, 3, -1, 0, 0};
        tbl[7]  = '{20'h00000, 5, 5, 5, 1, 2, 1, 1, 0, 0, 0, 'h1, 3, -1, 0, 0};
        tbl[8]  = '{20'h00000, 8, 8, 0, 1, 2, 1, 0, 1, 0, 0, 0, -1, 2, 0, 0};
        tbl[9]  = '{20'h00000, 10, 4, 5, 3, 2, 1, 0, 1, 0, 0, 0, -1, 2, 0, 0};
        tbl[10] = '{20'h12345, 20, 30, 3, 3, 3, 3, 6, 0, 'h12345, 'h12903, 'h1FF, 3, -1, 0, 0};

        repeat (3) @(negedge clk);
        check("reset state",
              {fill_clear, fill_enable, initial_address, offset,
               write_enable, tile_valid, busy, done, err}, 0);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_layer(tbl[i].base, tbl[i].h, tbl[i].w, tbl[i].k, tbl[i].c,
                      tbl[i].fd, tbl[i].rd, 0);
            check({tag, " ntiles"}, q_addr.size(), tbl[i].n_tiles);
            check({tag, " err"}, r_err, tbl[i].e_err);
            if (tbl[i].fe_at >= 0) check({tag, " fe latency"}, r_first_fe, tbl[i].fe_at);
            else check({tag, " no fill"}, r_first_fe, -1);
            if (tbl[i].done_at >= 0) check({tag, " done latency"}, r_done_at, tbl[i].done_at);
            if (tbl[i].n_tiles > 0 && q_addr.size() == tbl[i].n_tiles) begin
                check({tag, " addr0"}, q_addr[0], tbl[i].a0);
                check({tag, " addr last"}, q_addr[$], tbl[i].alast);
                check({tag, " mask last"}, q_mask[$], tbl[i].mlast);
            end
            if (tbl[i].fe_cyc > 0)
                foreach (q_fe[j]) check($sformatf("%s fe cycles[%0d]", tag, j), q_fe[j], tbl[i].fe_cyc);
            if (tbl[i].tv_cyc > 0)
                foreach (q_tv[j]) check($sformatf("%s tv cycles[%0d]", tag, j), q_tv[j], tbl[i].tv_cyc);
            model_check(tag, tbl[i].base, tbl[i].h, tbl[i].w, tbl[i].k, tbl[i].c);
        end

        // Abort during the second tile's fill, then a clean full layer.
        run_layer(20'h00100, 28, 28, 3, 1, 1000, 0, 2);
        check("abort dones", dones, 0);
        check("abort idle busy", busy, 0);
        run_layer(20'h00100, 28, 28, 3, 1, 2, 1, 0);
        model_check("after reset", 20'h00100, 28, 28, 3, 1);

        for (int i = 0; i < 10; i++) begin
            logic [19:0] b;
            int h, w, k, c;
            b = ($urandom_range(0, 3) == 0) ? 20'hFFFFF - 20'($urandom_range(0, 2000))
                                           : 20'($urandom);
            h = $urandom_range(1, 40);
            w = $urandom_range(1, 40);
            k = $urandom_range(0, 6);
            c = $urandom_range(0, 3);
            run_layer(b, h, w, k, c, $urandom_range(0, 4), $urandom_range(0, 4), 0);
            model_check($sformatf("rand%0d", i), b, h, w, k, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
